fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline.
- Consumes the current PC from program_counter (pc_out) and computes the next PC that program_counter loads (pc_in): sequential, branch, jump, or hold.
- Drives the instruction-memory read and owns the IF/ID pipeline register.
- Contains a small boot/run/wait FSM and fetch/bubble performance counters.

Parameters:
RESET_VEC, 32'h0000_0000, first PC issued after reset release
IMEM_AW, 10, instruction-memory word-address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock (shared with program_counter)
reset_n  in  1  asynchronous, active-low reset
pc_cur  in  32  current PC, from program_counter pc_out
pc_next  out  32  next PC, to program_counter pc_in
imem_req  out  1  read request this cycle
imem_addr  out  IMEM_AW  word address = pc_cur[IMEM_AW+1:2]
imem_rdata  in  32  instruction at imem_addr, combinational, same cycle
imem_ready  in  1  imem_rdata valid this cycle
stall  in  1  hazard unit: hold PC and IF/ID
br_taken  in  1  taken branch resolved in EX
br_target  in  32  branch target
jump  in  1  J/JAL decoded in ID
jump_index  in  26  J-format index field
ifid_instr  out  32  IF/ID instruction
ifid_pc4  out  32  IF/ID PC+4
ifid_valid  out  1  IF/ID holds a real instruction
ifid_misalign  out  1  the redirect that fetched this instruction had target[1:0]!=0
fetch_cnt  out  CNT_W  valid IF/ID loads, saturating
bubble_cnt  out  CNT_W  bubbles inserted by imem_ready=0, saturating

Behaviour:
- Reset (reset_n=0, async) sets:
  - pc_next=RESET_VEC, imem_req=0.
  - ifid_instr=32'h0 (NOP), ifid_pc4=0, ifid_valid=0, ifid_misalign=0.
  - Both counters 0; state=BOOT.
- FSM states: BOOT, RUN, WAIT.
  - BOOT: pc_next=RESET_VEC; imem_req=0; IF/ID not loaded; next state RUN unconditionally. program_counter captures RESET_VEC at this edge.
  - RUN->WAIT: imem_req=1, imem_ready=0, and no redirect.
  - WAIT->RUN: imem_ready=1 or any redirect.
  - WAIT behaves like RUN apart from the bubble accounting below.
- imem_req = (state!=BOOT) & ~stall.
- Per-cycle priority in RUN/WAIT, highest first:
  1. br_taken:
     - pc_next = {br_target[31:2],2'b00}.
     - IF/ID gets a bubble: valid=0, instr=0. Applies even when stall=1 (branch overrides stall).
     - Misalign latch set iff br_target[1:0]!=0.
  2. jump & ~stall:
     - pc_next = {pc_cur[31:28], jump_index, 2'b00}, where pc_cur is the PC of the instruction after the jump.
     - IF/ID gets a bubble. There is no delay slot.
     - jump is ignored while stall=1; the ID instruction re-presents it.
  3. stall: pc_next=pc_cur; IF/ID holds every field.
  4. imem_ready=0: pc_next=pc_cur; IF/ID gets a bubble; bubble_cnt+1.
  5. Otherwise (sequential fetch):
     - pc_next=pc_cur+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
     - IF/ID <= {imem_rdata, pc_cur+4, valid=1, misalign=latch}; latch is then cleared.
     - fetch_cnt+1.
- pc_next is combinational from the state and inputs above. IF/ID registers and counters update on posedge clk.
- Counters saturate at all-ones and never wrap.
- Simultaneous br_taken & jump: the branch wins (older instruction).
- Reset asserted mid-operation: immediate return to the reset values above; the first cycle after release is BOOT.

Decomposition:
- Shared package mips_pkg holds: NOP_INSTR (32'h0), the FSM state encoding (BOOT/RUN/WAIT), and the J-target concatenation as a constant function.
- One natural sub-module: next_pc_mux (combinational priority select plus the +4 adder).
- fetch_stage owns the FSM, the IF/ID register and the counters.

Test Plan:
- Reset and sequential fetch: hold reset_n=0 for 3 cycles, then release; a PC model feeds back pc_next; imem returns 32'h2008_0005 with ready=1.
  -> Cycle 1: pc_next=0, ifid_valid=0.
  -> Next three edges: ifid_pc4=4, 8, 12; ifid_instr=32'h2008_0005; fetch_cnt=3.
- Branch redirect: at pc_cur=32'h10, br_taken=1, br_target=32'h80.
  -> pc_next=32'h80, then ifid_valid=0.
  -> Next fetch: ifid_pc4=32'h84.
  -> Repeat with target 32'h82: pc_next=32'h80 and the fetched instruction has ifid_misalign=1.
- Jump: pc_cur=32'h1000_0020, jump=1, jump_index=26'h40.
  -> pc_next=32'h1000_0100; the IF/ID slot is a bubble.
  -> Same inputs with stall=1: pc_next=32'h1000_0020 and IF/ID unchanged.
- Stall with simultaneous branch: stall=1, br_taken=1, br_target=32'h200.
  -> pc_next=32'h200, ifid_valid=0.
  -> Stall alone for 2 cycles: pc_next=pc_cur and IF/ID unchanged.
- Memory wait: imem_ready=0 for 2 cycles at pc_cur=32'h40.
  -> pc_next=32'h40 both cycles; state=WAIT; bubble_cnt=2.
  -> On ready: ifid_pc4=32'h44; state returns to RUN.
- Async reset mid-run: drop reset_n between clock edges at pc_cur=32'h30.
  -> All outputs take reset values before the next edge.
  -> After release: BOOT, pc_next=RESET_VEC, counters 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: NOP encoding, fetch FSM states and J-target helper.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Outcome of the per-cycle next-PC priority decision.
    typedef enum logic [2:0] {
        SEL_BOOT    = 3'd0,
        SEL_BRANCH  = 3'd1,
        SEL_JUMP    = 3'd2,
        SEL_STALL   = 3'd3,
        SEL_WAITMEM = 3'd4,
        SEL_SEQ     = 3'd5
    } next_sel_t;

    function automatic logic [31:0] j_target(input logic [3:0] pc_hi, input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_next_pc_mux.sv
// Next-PC priority select (boot, branch, jump, stall, memory wait, sequential) plus the +4 adder.
module next_pc_mux
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        boot_i,
    input  logic [31:0] pc_cur_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [29:0] br_target_hi_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        imem_ready_i,
    output logic [31:0] pc_next_o,
    output logic [31:0] pc_plus4_o,
    output logic [2:0]  sel_o
);

    assign pc_plus4_o = pc_cur_i + 32'd4;

    // A taken branch belongs to an older instruction, so it beats both jump and stall.
    always_comb begin
        sel_o     = SEL_SEQ;
        pc_next_o = pc_plus4_o;
        if (boot_i) begin
            sel_o     = SEL_BOOT;
            pc_next_o = RESET_VEC;
        end else if (br_taken_i) begin
            sel_o     = SEL_BRANCH;
            pc_next_o = {br_target_hi_i, 2'b00};
        end else if (jump_i && !stall_i) begin
            sel_o     = SEL_JUMP;
            pc_next_o = j_target(pc_cur_i[31:28], jump_index_i);
        end else if (stall_i) begin
            sel_o     = SEL_STALL;
            pc_next_o = pc_cur_i;
        end else if (!imem_ready_i) begin
            sel_o     = SEL_WAITMEM;
            pc_next_o = pc_cur_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: boot/run/wait FSM, IF/ID pipeline register and
// saturating fetch/bubble counters around the next-PC mux.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter int          CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        pc_cur,
    output logic [31:0]        pc_next,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ready,
    input  logic               stall,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    input  logic               jump,
    input  logic [25:0]        jump_index,
    output logic [31:0]        ifid_instr,
    output logic [31:0]        ifid_pc4,
    output logic               ifid_valid,
    output logic               ifid_misalign,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fetch_state_t     state_q;
    logic [2:0]       sel;
    logic [31:0]      pc_plus4;
    logic             redirect;

    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc4_q, pc4_d;
    logic             valid_q, valid_d;
    logic             mis_q, mis_d;
    logic             latch_q, latch_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;

    next_pc_mux #(
        .RESET_VEC(RESET_VEC)
    ) u_next_pc_mux (
        .boot_i        (state_q == BOOT),
        .pc_cur_i      (pc_cur),
        .stall_i       (stall),
        .br_taken_i    (br_taken),
        .br_target_hi_i(br_target[31:2]),
        .jump_i        (jump),
        .jump_index_i  (jump_index),
        .imem_ready_i  (imem_ready),
        .pc_next_o     (pc_next),
        .pc_plus4_o    (pc_plus4),
        .sel_o         (sel)
    );

    assign imem_req  = (state_q != BOOT) && !stall;
    assign imem_addr = pc_cur[IMEM_AW+1:2];
    assign redirect  = (sel == SEL_BRANCH) || (sel == SEL_JUMP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
        end else begin
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     if (imem_req && !imem_ready && !redirect) state_q <= WAIT;
                WAIT:    if (imem_ready || redirect) state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    // The misalign latch remembers the last redirect until the instruction it fetched lands in IF/ID.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        latch_d = latch_q;
        fcnt_d  = fcnt_q;
        bcnt_d  = bcnt_q;
        case (sel)
            SEL_BRANCH: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                mis_d   = 1'b0;
                latch_d = |br_target[1:0];
            end
            SEL_JUMP: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                mis_d   = 1'b0;
                latch_d = 1'b0;
            end
            SEL_WAITMEM: begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
                mis_d   = 1'b0;
                bcnt_d  = sat_inc(bcnt_q);
            end
            SEL_SEQ: begin
                instr_d = imem_rdata;
                pc4_d   = pc_plus4;
                valid_d = 1'b1;
                mis_d   = latch_q;
                latch_d = 1'b0;
                fcnt_d  = sat_inc(fcnt_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            latch_q <= 1'b0;
            fcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            latch_q <= latch_d;
            fcnt_q  <= fcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign ifid_instr    = instr_q;
    assign ifid_pc4      = pc4_q;
    assign ifid_valid    = valid_q;
    assign ifid_misalign = mis_q;
    assign fetch_cnt     = fcnt_q;
    assign bubble_cnt    = bcnt_q;

endmodule
